gcd32_arbiter: RTL and testbench

GCD32_ARBITER -- requirements
Module: gcd32_arbiter

---
 rtl/gcd32_arbiter.sv | 97 +++++++++
 tb/tb_gcd32_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/gcd32_arbiter.sv
// gcd32_arbiter: round-robin arbiter sharing one 32-bit GCD core among NREQ requesters.
// Ports: clk, resetn (sync, active-low); req/x_req/y_req/ack request side;
// rsp_valid/rsp_ready/rsp_data/rsp_err response side; gcd_start/gcd_x/gcd_y/gcd_done/gcd_out
// core side; busy high outside IDLE. Define GCD_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module gcd32_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   x_req,
  input  logic [32*NREQ-1:0]   y_req,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 gcd_start,
  output logic [31:0]          gcd_x,
  output logic [31:0]          gcd_y,
  input  logic                 gcd_done,
  input  logic [31:0]          gcd_out,
  output logic                 busy
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, next_state;
  logic [GW-1:0] last_grant, grant, pick;
  logic tmo;
  // Walk from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    pick = last_grant;
    for (int i = NREQ; i >= 1; i--)
      if (req[GW'(int'(last_grant) + i)]) pick = GW'(int'(last_grant) + i);
  end
`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  // Cleared while in START so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk)
    if (!resetn || state == START) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
  assign tmo = state == WAIT && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (!resetn) rsp_err <= 1'b0;
    else if (state == WAIT && gcd_done) rsp_err <= 1'b0;
    else if (tmo) rsp_err <= 1'b1;
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = |req ? START : IDLE;
      START:   next_state = WAIT;
      WAIT:    next_state = (gcd_done || tmo) ? RESP : WAIT;
      default: next_state = rsp_ready[grant] ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      ack        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      gcd_start  <= 1'b0;
      gcd_x      <= '0;
      gcd_y      <= '0;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
    end else begin
      ack       <= '0;
      gcd_start <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= pick;
          ack   <= NREQ'(1) << pick;
          gcd_x <= x_req[32*pick +: 32];
          gcd_y <= y_req[32*pick +: 32];
        end
        START: gcd_start <= 1'b1;
        WAIT: if (gcd_done || tmo) begin
          rsp_data  <= gcd_done ? gcd_out : '0;
          rsp_valid <= NREQ'(1) << grant;
        end
        default: if (rsp_ready[grant]) begin
          rsp_valid  <= '0;
          last_grant <= grant;
        end
      endcase
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_gcd32_arbiter.sv
// tb_gcd32_arbiter: directed table-driven bench for gcd32_arbiter.
module tb_gcd32_arbiter;
  logic clk = 0, resetn = 0;
  logic [3:0] req = 0, ack, rsp_valid, rsp_ready = 0;
  logic [127:0] x_req = 0, y_req = 0;
  logic [31:0] rsp_data, gcd_x, gcd_y, gcd_out = 0;
  logic rsp_err, gcd_start, gcd_done = 0, busy;
  int total = 0, bad = 0;
  typedef struct {int g; logic [31:0] x, y, res; int hold;} vec_t;
  vec_t vt[4];
  always #5 clk = ~clk;
  gcd32_arbiter #(.NREQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .x_req(x_req), .y_req(y_req), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gcd_start(gcd_start), .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_done(gcd_done),
    .gcd_out(gcd_out), .busy(busy));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    resetn = 0; req = 0; rsp_ready = 0; gcd_done = 0;
    @(negedge clk); @(negedge clk);
    resetn = 1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_gcd_start"}, 32'(gcd_start), 0);
    chk({tag, "_gcd_x"}, gcd_x, 0);
    chk({tag, "_gcd_y"}, gcd_y, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  task automatic wait_ack(input int g, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (ack == 0 && n < 10) begin @(negedge clk); n++; end
    chk("ack_lat", 32'(n), 1);
    chk("ack", 32'(ack), 32'(4'b1 << g));
    chk("gcd_x", gcd_x, x);
    chk("gcd_y", gcd_y, y);
    req[g] = 0;
    @(negedge clk);
    chk("ack_pulse", 32'(ack), 0);
    chk("gcd_start", 32'(gcd_start), 1);
    @(negedge clk);
    chk("start_pulse", 32'(gcd_start), 0);
    chk("busy", 32'(busy), 1);
  endtask
  task automatic txn(input vec_t v);
    wait_ack(v.g, v.x, v.y);
    gcd_done = 1; gcd_out = v.res;
    @(negedge clk);
    gcd_done = 0; gcd_out = 32'hdead_beef;
    chk("rsp_valid", 32'(rsp_valid), 32'(4'b1 << v.g));
    chk("rsp_data", rsp_data, v.res);
    chk("rsp_err", 32'(rsp_err), 0);
    rsp_ready = ~(4'b1 << v.g);
    repeat (v.hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'(4'b1 << v.g));
      chk("hold_data", rsp_data, v.res);
      chk("hold_ack", 32'(ack), 0);
      chk("hold_start", 32'(gcd_start), 0);
    end
    rsp_ready = 4'hf;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_clear", 32'(rsp_valid), 0);
    chk("no_same_cycle_ack", 32'(ack), 0);
    chk("idle", 32'(busy), 0);
  endtask
  initial begin
    vt[0] = '{0, 12, 8, 4, 0};
    vt[1] = '{1, 35, 14, 7, 0};
    vt[2] = '{2, 17, 5, 1, 10};
    vt[3] = '{3, 100, 75, 25, 0};
    do_reset();
    chk_zero("reset");
    x_req[31:0] = 48; y_req[31:0] = 18;
    req = 4'b0001;
    txn('{0, 48, 18, 6, 0});
    do_reset();
    for (int i = 0; i < 4; i++) begin
      x_req[32*i +: 32] = vt[i].x;
      y_req[32*i +: 32] = vt[i].y;
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) txn(vt[i]);
    do_reset();
    gcd_done = 1; gcd_out = 99;
    @(negedge clk);
    gcd_done = 0;
    @(negedge clk);
    chk("stray_valid", 32'(rsp_valid), 0);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_data", rsp_data, 0);
    req = 4'b0100;
    wait_ack(2, 17, 5);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    chk_zero("midreset");
    gcd_done = 1; gcd_out = 1;
    @(negedge clk);
    gcd_done = 0;
    @(negedge clk);
    chk("late_done_valid", 32'(rsp_valid), 0);
    chk("late_done_busy", 32'(busy), 0);
    req = 4'b1111;
    txn(vt[0]);
`ifdef GCD_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0001;
    begin
      int n = 0;
      while (gcd_start == 0 && n < 10) begin @(negedge clk); n++; end
      req = 0;
      n = 0;
      while (rsp_valid == 0 && n < 40) begin @(negedge clk); n++; end
      chk("tmo_lat", 32'(n), 16);
      chk("tmo_valid", 32'(rsp_valid), 1);
      chk("tmo_err", 32'(rsp_err), 1);
      chk("tmo_data", rsp_data, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
